// File: rtl/fpu_mul_arbiter.sv
// Shares one floating-point multiply unit between two requesters, round-robin arbitrated.
// Latency: accept at T, mu_trig at T+1, response the cycle after mu_vld (T+3 minimum).
// Backpressure: one transaction in flight, and requests wait in IDLE; responses cannot be stalled.
//
// Ports:
//   sys_clk, sys_rst            clock and synchronous active-high reset
//   reqN_vld/rdy, reqN_a/b      requester N operand handshake (rdy is combinational in IDLE)
//   rspN_vld/data/err           one-cycle result pulse to requester N (err = timeout substitute)
//   mu_data1/2, mu_trig         operands and start pulse to the multiply unit
//   mu_data, mu_vld             multiply unit result
//   busy                        high whenever the FSM is not in IDLE
// Build option: define FPU_MUL_ARBITER_TIMEOUT_EN to enable the WAIT-state timeout
// (TIMEOUT_CYCLES WAIT cycles without mu_vld returns quiet NaN 0x7FC00000 with err=1).
`timescale 1ns/1ps

module fpu_mul_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req0_vld,
    output logic        req0_rdy,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_vld,
    output logic        req1_rdy,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_vld,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_vld,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic [31:0] mu_data1,
    output logic [31:0] mu_data2,
    output logic        mu_trig,
    input  logic [31:0] mu_data,
    input  logic        mu_vld,
    output logic        busy
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   ptr;      // requester that wins when both are valid
    logic   owner;    // requester of the transaction in flight
    logic   gnt_any;
    logic   gnt_sel;

    // A lone valid requester always wins; the pointer only breaks ties.
    always_comb begin
        gnt_any = req0_vld | req1_vld;
        if (req0_vld && req1_vld) begin
            gnt_sel = ptr;
        end else begin
            gnt_sel = req1_vld;
        end
    end

    // Gated by reset so nothing is accepted on the cycle the FSM is being cleared.
    assign req0_rdy = !sys_rst && (state == IDLE) && gnt_any && !gnt_sel;
    assign req1_rdy = !sys_rst && (state == IDLE) && gnt_any &&  gnt_sel;

    logic        wait_done;
    logic [31:0] res_data;

`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    logic [7:0] tmo_cnt;   // WAIT cycles already spent, 0 on the first WAIT cycle
    logic       tmo_hit;
    logic       res_err;

    // A real result arriving on the limit cycle takes precedence over the timeout.
    always_comb begin
        tmo_hit   = !mu_vld && (tmo_cnt == TMO_LAST);
        wait_done = mu_vld || tmo_hit;
        res_data  = tmo_hit ? QNAN : mu_data;
        res_err   = tmo_hit;
    end
`else
    always_comb begin
        wait_done = mu_vld;
        res_data  = mu_data;
    end

    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mu_trig   <= 1'b0;
            mu_data1  <= '0;
            mu_data2  <= '0;
            rsp0_vld  <= 1'b0;
            rsp1_vld  <= 1'b0;
            rsp0_data <= '0;
            rsp1_data <= '0;
`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
            rsp0_err  <= 1'b0;
            rsp1_err  <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            mu_trig  <= 1'b0;
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner    <= gnt_sel;
                        ptr      <= ~gnt_sel;
                        mu_data1 <= gnt_sel ? req1_a : req0_a;
                        mu_data2 <= gnt_sel ? req1_b : req0_b;
                        mu_trig  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        state <= RESP;
                        if (owner) begin
                            rsp1_vld  <= 1'b1;
                            rsp1_data <= res_data;
`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
                            rsp1_err  <= res_err;
`endif
                        end else begin
                            rsp0_vld  <= 1'b1;
                            rsp0_data <= res_data;
`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
                            rsp0_err  <= res_err;
`endif
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mu_data1 <= '0;
                    mu_data2 <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 8'd1 : 8'd0;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
`timescale 1ns/1ps

module tb_fpu_mul_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_vld = 1'b0, req1_vld = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_vld, rsp1_vld, rsp0_err, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] mu_data1, mu_data2;
    logic        mu_trig, busy;
    logic [31:0] mu_data;
    logic        mu_vld;

    // Multiply-unit stub output, plus an independent spurious-pulse source.
    logic        mu_vld_m = 1'b0, spur_vld = 1'b0;
    logic [31:0] mu_dat_m = '0, spur_dat = '0;
    int          mu_lat = 1;
    bit          mu_en = 1'b1;
    logic [31:0] ma, mb;

    assign mu_vld  = mu_vld_m | spur_vld;
    assign mu_data = spur_vld ? spur_dat : mu_dat_m;

    always #5 clk = ~clk;

    fpu_mul_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .req0_vld (req0_vld),
        .req0_rdy (req0_rdy),
        .req0_a   (req0_a),
        .req0_b   (req0_b),
        .req1_vld (req1_vld),
        .req1_rdy (req1_rdy),
        .req1_a   (req1_a),
        .req1_b   (req1_b),
        .rsp0_vld (rsp0_vld),
        .rsp0_data(rsp0_data),
        .rsp0_err (rsp0_err),
        .rsp1_vld (rsp1_vld),
        .rsp1_data(rsp1_data),
        .rsp1_err (rsp1_err),
        .mu_data1 (mu_data1),
        .mu_data2 (mu_data2),
        .mu_trig  (mu_trig),
        .mu_data  (mu_data),
        .mu_vld   (mu_vld),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    logic [31:0] last0 = '0, last1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] d, input logic e, input int lat);
        exp_t x;
        x.port = p;
        x.data = d;
        x.err  = e;
        x.lat  = lat;
        sb.push_back(x);
    endtask

    // Hand-computed IEEE754 single products known to the multiply-unit stub.
    function automatic logic [31:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000; // 2.0 * 3.0 = 6.0
            {32'h3FC00000, 32'h40000000}: return 32'h40400000; // 1.5 * 2.0 = 3.0
            {32'h3F800000, 32'hC0A00000}: return 32'hC0A00000; // 1.0 * -5.0 = -5.0
            {32'h40800000, 32'h3E800000}: return 32'h3F800000; // 4.0 * 0.25 = 1.0
            default:                      return 32'h00000000;
        endcase
    endfunction

    // Multiply-unit stub: answers mu_lat cycles after it sees mu_trig.
    initial forever begin
        @(negedge clk);
        if (mu_trig === 1'b1 && mu_en) begin
            ma = mu_data1;
            mb = mu_data2;
            repeat (mu_lat) @(posedge clk);
            #1;
            mu_dat_m = mul_lut(ma, mb);
            mu_vld_m = 1'b1;
            @(posedge clk);
            #1;
            mu_vld_m = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every response pulse.
    initial begin
        exp_t        e;
        logic [31:0] d;
        logic        er;
        forever begin
            @(negedge clk);
            if (rst) begin
                last0 = '0;
                last1 = '0;
            end
            if (req0_rdy === 1'b1 || req1_rdy === 1'b1) gnt_cyc = cyc;
            if (req0_rdy === 1'b1 && req1_rdy === 1'b1) begin
                n_chk++;
                n_fail++;
                $display("FAIL rdy_onehot: both rdy high, required at most one (cycle %0d)", cyc);
            end
            if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp0_vld=%b rsp1_vld=%b, required none (cycle %0d)",
                             rsp0_vld, rsp1_vld, cyc);
                end else begin
                    e  = sb.pop_front();
                    d  = e.port ? rsp1_data : rsp0_data;
                    er = e.port ? rsp1_err : rsp0_err;
                    check("rsp_vld_sel", 32'({rsp1_vld, rsp0_vld}), e.port ? 32'd2 : 32'd1);
                    check("rsp_data", d, e.data);
                    check("rsp_err", 32'(er), 32'(e.err));
                    check("rsp_latency", cyc - gnt_cyc, e.lat);
                    if (e.port) begin
                        check("rsp0_hold", rsp0_data, last0);
                        last1 = e.data;
                    end else begin
                        check("rsp1_hold", rsp1_data, last1);
                        last0 = e.data;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("drain", sb.size(), 0);
        tick();
    endtask

    // Single-requester transaction; returns one cycle into WAIT.
    task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int elat, input bit spur,
                        input bit push, input logic [31:0] edat, input logic eerr);
        logic seen = 1'b0;
        mu_lat = lat;
        if (push) push_exp(p, edat, eerr, elat);
        if (p) begin
            req1_a = a; req1_b = b; req1_vld = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_vld = 1'b1;
        end
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = p ? req1_rdy : req0_rdy;
        end
        check("rdy_seen", 32'(seen), 32'd1);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        if (spur) begin
            spur_dat = 32'hDEADBEEF;
            spur_vld = 1'b1;
        end
        @(negedge clk);
        check("mu_trig", 32'(mu_trig), 32'd1);
        check("mu_data1", mu_data1, a);
        check("mu_data2", mu_data2, b);
        tick();
        spur_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   k;
        int   rc;
        logic order[4];

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mu_trig", 32'(mu_trig), 32'd0);
        check("rst_mu_data1", mu_data1, 32'd0);
        check("rst_mu_data2", mu_data2, 32'd0);
        check("rst_rsp_vld", 32'({rsp1_vld, rsp0_vld}), 32'd0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_rsp_err", 32'({rsp1_err, rsp0_err}), 32'd0);

        // Spurious mu_vld in IDLE
        tick();
        spur_dat = 32'h12345678;
        spur_vld = 1'b1;
        tick();
        spur_vld = 1'b0;
        @(negedge clk);
        check("idle_spur_busy", 32'(busy), 32'd0);
        tick();

        // req0 only, unit answers two cycles after trig
        send(1'b0, 32'h40000000, 32'h40400000, 2, 4, 1'b0, 1'b1, 32'h40C00000, 1'b0);
        wait_idle();
        // req1 only, minimum latency
        send(1'b1, 32'h3FC00000, 32'h40000000, 1, 3, 1'b0, 1'b1, 32'h40400000, 1'b0);
        wait_idle();
        // Spurious mu_vld in ISSUE must not complete the transaction
        send(1'b0, 32'h3F800000, 32'hC0A00000, 3, 5, 1'b1, 1'b1, 32'hC0A00000, 1'b0);
        wait_idle();

        // Both valid continuously after reset: grants alternate 0,1,0,1
        do_reset();
        mu_lat = 1;
        push_exp(1'b0, 32'h40C00000, 1'b0, 3);
        push_exp(1'b1, 32'h40400000, 1'b0, 3);
        push_exp(1'b0, 32'h40C00000, 1'b0, 3);
        push_exp(1'b1, 32'h40400000, 1'b0, 3);
        req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_a = 32'h3FC00000; req1_b = 32'h40000000;
        req0_vld = 1'b1;
        req1_vld = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 4; c++) begin
            @(negedge clk);
            if (req0_rdy) begin order[cnt] = 1'b0; cnt++; end
            else if (req1_rdy) begin order[cnt] = 1'b1; cnt++; end
        end
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        check("rr_count", cnt, 4);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
        wait_idle();

        // req1 only, three back-to-back: accept exactly one cycle after RESP
        mu_lat = 1;
        for (int i = 0; i < 3; i++) push_exp(1'b1, 32'h3F800000, 1'b0, 3);
        req1_a = 32'h40800000; req1_b = 32'h3E800000;
        req1_vld = 1'b1;
        k = 0;
        rc = -100;
        for (int c = 0; c < 80 && k < 3; c++) begin
            @(negedge clk);
            if (rsp1_vld) rc = cyc;
            if (req1_rdy) begin
                if (k > 0) check("b2b_gap", cyc - rc, 1);
                k++;
            end
        end
        tick();
        req1_vld = 1'b0;
        check("b2b_count", k, 3);
        wait_idle();

        // Reset during WAIT, late mu_vld must be ignored
        send(1'b0, 32'h40000000, 32'h40400000, 4, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp0_data", rsp0_data, 32'd0);
        tick();
        send(1'b1, 32'h3FC00000, 32'h40000000, 1, 3, 1'b0, 1'b1, 32'h40400000, 1'b0);
        wait_idle();

        // Unit never answers
        mu_en = 1'b0;
`ifdef FPU_MUL_ARBITER_TIMEOUT_EN
        send(1'b0, 32'h40000000, 32'h40400000, 1, TMO + 2, 1'b0, 1'b1, 32'h7FC00000, 1'b1);
        wait_idle();
        check("tmo_busy_after", 32'(busy), 32'd0);
`else
        send(1'b0, 32'h40000000, 32'h40400000, 1, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (30) @(negedge clk);
        check("hang_busy", 32'(busy), 32'd1);
        do_reset();
`endif
        mu_en = 1'b1;

        // Result arriving on the last permitted WAIT cycle is a normal result
        send(1'b1, 32'h40800000, 32'h3E800000, TMO, TMO + 2, 1'b0, 1'b1, 32'h3F800000, 1'b0);
        wait_idle();

        repeat (3) tick();
        check("final_queue", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_mul_arbiter.md
FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum WAIT-state cycles before a forced error response; legal range 2..255.
REQ-002 Port: sys_clk  input  1  single clock; all logic on its rising edge.
REQ-003 Port: sys_rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: req0_vld / req1_vld  input  1  requester N has an operand pair pending.
REQ-005 Ports: req0_rdy / req1_rdy  output  1  operand pair of requester N accepted this cycle.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  input  32 each  IEEE754 single operands.
REQ-007 Ports: rsp0_vld / rsp1_vld  output  1  one-cycle result pulse to requester N.
REQ-008 Ports: rsp0_data / rsp1_data  output  32  product for requester N.
REQ-009 Ports: rsp0_err / rsp1_err  output  1  result is a timeout substitute.
REQ-010 Ports: mu_data1, mu_data2  output  32 each  operands to the multiply unit.
REQ-011 Port: mu_trig  output  1  one-cycle start pulse to the multiply unit.
REQ-012 Ports: mu_data  input  32  multiply unit result; mu_vld  input  1  result valid.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL share one multiply unit between two requesters via FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: any reqN_vld high SHALL cause a grant; reqN_rdy SHALL be asserted combinationally in that cycle, operands latched, next state ISSUE.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last SHALL win; after reset requester 0 has priority.
REQ-017 The priority pointer SHALL update only on a grant; a single valid requester SHALL always be granted regardless of the pointer.
REQ-018 ISSUE: mu_trig SHALL be high for exactly one cycle; next state WAIT.
REQ-019 mu_data1/mu_data2 SHALL hold the latched operands, stable from ISSUE through WAIT, and 0 in IDLE.
REQ-020 WAIT: on mu_vld, mu_data SHALL be latched and next state RESP; mu_vld in IDLE, ISSUE or RESP SHALL be ignored.
REQ-021 RESP: rspN_vld SHALL pulse for one cycle only for the granted requester, with rspN_data and rspN_err valid that cycle; next state IDLE.
REQ-022 Non-granted rsp ports SHALL hold vld=0; rspN_data SHALL keep its last value.
REQ-023 Minimum latency: rdy at cycle T, mu_trig at T+1, mu_vld no earlier than T+2, rsp_vld the cycle after mu_vld (T+3 minimum).
REQ-024 No new request SHALL be accepted before the RESP cycle completes (back-to-back accept earliest at RESP+1).
REQ-025 Responses SHALL have no backpressure; requesters must sample on rsp_vld.

Reset
REQ-026 On sys_rst high at a clock edge: state IDLE, pointer to requester 0, all outputs 0, operand/result registers 0, timeout counter 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it with no response pulse; a later mu_vld SHALL be ignored.

Configuration
REQ-028 Macro FPU_MUL_ARBITER_TIMEOUT_EN defined: a counter SHALL run in WAIT; if TIMEOUT_CYCLES WAIT cycles elapse without mu_vld, next state RESP with rspN_data=0x7FC00000 and rspN_err=1.
REQ-029 mu_vld in the same cycle the limit is reached SHALL win (normal result, err=0).
REQ-030 Macro undefined: no counter; WAIT persists until mu_vld; rsp0_err and rsp1_err tied 0.

Verification
REQ-031 req0 only, a=0x40000000, b=0x40400000, unit returns 0x40C00000 two cycles after trig -> rsp0_vld one cycle with 0x40C00000, err=0, rsp1_vld stays 0.
REQ-032 Both valid continuously for 4 transactions after reset -> grant order 0,1,0,1; each rdy a single-cycle pulse.
REQ-033 req1 only, three back-to-back transactions -> all granted to 1; next accept exactly one cycle after each RESP.
REQ-034 sys_rst pulse during WAIT, then mu_vld -> no rsp pulse, busy=0, next request proceeds normally.
REQ-035 Macro defined, TIMEOUT_CYCLES=8, mu_vld never asserted -> rsp_vld 8 WAIT cycles later with 0x7FC00000, err=1; macro undefined -> busy stays high, no rsp.
REQ-036 Spurious mu_vld in IDLE and ISSUE -> no state change, no rsp pulse.
